// File: rtl/mem_stage.sv
// Memory-access stage: one-outstanding-request handshake to data memory,
// load lane extraction with sign/zero extension, store lane/strobe alignment.
module mem_stage #(
  parameter int BUS_WIDTH  = 64,
  parameter int STRB_WIDTH = BUS_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [BUS_WIDTH-1:0]  alu_fpu_result,
  input  logic [BUS_WIDTH-1:0]  store_data,
  input  logic                  dmem_ready,
  input  logic [BUS_WIDTH-1:0]  dmem_rdata,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [BUS_WIDTH-1:0]  dmem_addr,
  output logic [BUS_WIDTH-1:0]  dmem_wdata,
  output logic [STRB_WIDTH-1:0] dmem_wstrb,
  output logic                  mem_stall,
  output logic                  mem_fault,
  output logic [BUS_WIDTH-1:0]  mem_result
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t               r_state;
  logic [BUS_WIDTH-1:0] r_load_buf;

  logic                  w_access;
  logic                  w_store;
  logic                  w_load;
  logic [2:0]            w_a;
  logic [5:0]            w_shamt;
  logic                  w_misalign;
  logic                  w_fault;
  logic                  w_go;
  logic                  w_in_req;
  logic [BUS_WIDTH-1:0]  w_field;
  logic [BUS_WIDTH-1:0]  w_load_ext;
  logic [STRB_WIDTH-1:0] w_base_strb;

  assign w_access = mem_read | mem_write;
  assign w_store  = mem_write;
  assign w_load   = mem_read & ~mem_write;
  assign w_a      = alu_fpu_result[2:0];
  assign w_shamt  = {w_a, 3'b000};

  always_comb begin
    w_misalign = 1'b0;
    case (funct3[1:0])
      2'b01:   w_misalign = w_a[0];
      2'b10:   w_misalign = |w_a[1:0];
      2'b11:   w_misalign = |w_a;
      default: w_misalign = 1'b0;
    endcase
  end

  // Stores have no unsigned variants, so funct3[2] on a store is reserved.
  assign w_fault = w_access & (w_misalign | (funct3 == 3'b111) | (w_store & funct3[2]));
  assign w_go    = w_access & ~w_fault;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_load_buf <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_go) r_state <= S_REQ;
        S_REQ: begin
          if (dmem_ready) begin
            r_load_buf <= dmem_rdata;
            r_state    <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_field = r_load_buf >> w_shamt;

  always_comb begin
    w_load_ext = w_field;
    case (funct3)
      3'b000: w_load_ext = {{56{w_field[7]}},  w_field[7:0]};
      3'b001: w_load_ext = {{48{w_field[15]}}, w_field[15:0]};
      3'b010: w_load_ext = {{32{w_field[31]}}, w_field[31:0]};
      3'b100: w_load_ext = {56'd0, w_field[7:0]};
      3'b101: w_load_ext = {48'd0, w_field[15:0]};
      3'b110: w_load_ext = {32'd0, w_field[31:0]};
      default: w_load_ext = w_field;
    endcase
  end

  always_comb begin
    w_base_strb = '1;
    case (funct3[1:0])
      2'b00:   w_base_strb = 8'h01;
      2'b01:   w_base_strb = 8'h03;
      2'b10:   w_base_strb = 8'h0F;
      default: w_base_strb = 8'hFF;
    endcase
  end

  // Reset gating keeps the bus quiet in the very cycle rst rises.
  assign w_in_req   = (r_state == S_REQ) & ~rst;
  assign dmem_req   = w_in_req;
  assign dmem_we    = w_in_req & w_store;
  assign dmem_addr  = w_in_req ? {alu_fpu_result[BUS_WIDTH-1:3], 3'b000} : '0;
  assign dmem_wdata = w_in_req ? (store_data << w_shamt) : '0;
  assign dmem_wstrb = w_in_req ? (w_base_strb << w_a) : '0;

  assign mem_stall  = ~rst & (((r_state == S_IDLE) & w_go) | (r_state == S_REQ));
  assign mem_fault  = w_fault;

  always_comb begin
    mem_result = alu_fpu_result;
    if (w_fault)
      mem_result = '0;
    else if ((r_state == S_DONE) && w_load)
      mem_result = w_load_ext;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage placed directly downstream of the execute stage. It takes the execute result as an effective address or pass-through value and runs a one-outstanding-request handshake to data memory. Load data is lane-extracted and sign/zero-extended; stores get byte-lane strobes. A stall is raised for the pipeline while an access is in flight, and misaligned or reserved accesses are flagged without touching memory.

## Interface
- BUS_WIDTH, 64, datapath, address and memory word width; only 64 is supported.
- STRB_WIDTH, 8, byte strobes per memory word; always BUS_WIDTH/8.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- mem_read  input  1  current instruction is a load.
- mem_write  input  1  current instruction is a store; wins if both set.
- funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU, 111 reserved.
- alu_fpu_result  input  BUS_WIDTH  execute result: effective address, or pass-through value.
- store_data  input  BUS_WIDTH  rs2 value, low bytes significant.
- dmem_ready  input  1  memory accepts/completes the current request this cycle.
- dmem_rdata  input  BUS_WIDTH  read word; valid when dmem_req && dmem_ready && !dmem_we.
- dmem_req  output  1  request valid.
- dmem_we  output  1  1 = write.
- dmem_addr  output  BUS_WIDTH  {alu_fpu_result[63:3], 3'b000}.
- dmem_wdata  output  BUS_WIDTH  store data shifted to the addressed lane.
- dmem_wstrb  output  STRB_WIDTH  byte enables, shifted by addr[2:0].
- mem_stall  output  1  hold all upstream stages this cycle.
- mem_fault  output  1  misaligned or reserved access; no memory access.
- mem_result  output  BUS_WIDTH  value for the MEM/WB register.

## Operation
- An access is any cycle with mem_read or mem_write set. Let a = alu_fpu_result[2:0].
- Fault conditions:
  - Halfword with a[0] != 0.
  - Word with a[1:0] != 0.
  - Doubleword with a != 0.
  - funct3 = 111.
  - Store with funct3[2] = 1.
- A faulting access is combinational: mem_fault = 1, mem_stall = 0, mem_result = 0, no request issued.
- The FSM has three states: IDLE, REQ and DONE.
- IDLE:
  - A non-faulting access asserts mem_stall = 1 and moves to REQ.
  - Otherwise the FSM stays in IDLE and mem_result = alu_fpu_result.
- REQ:
  - dmem_req = 1 and mem_stall = 1.
  - dmem_we = mem_write. dmem_addr, dmem_wdata and dmem_wstrb are driven from the held inputs.
  - When dmem_ready = 1, the FSM captures dmem_rdata into load_buf and moves to DONE.
  - Otherwise it stays in REQ with all request outputs stable.
- DONE:
  - mem_stall = 0, so the pipeline advances at this edge.
  - For a load, mem_result is the extended load; for a store, mem_result = alu_fpu_result.
  - The next state is always IDLE.
- Load extract: the field is load_buf >> (8*a), truncated to 8/16/32/64 bits. It is sign-extended for B/H/W and zero-extended for BU/HU/WU.
- Store lanes:
  - dmem_wdata = store_data << (8*a).
  - dmem_wstrb = base << a, where base is 0x01 (B), 0x03 (H), 0x0F (W) or 0xFF (D).
- When dmem_req = 0, dmem_we, dmem_addr, dmem_wdata and dmem_wstrb are driven to 0.
- Both mem_read and mem_write set: treated as a store.
- Back-to-back accesses: DONE returns to IDLE, so a following access starts one cycle after the previous DONE.

## Timing
- Reset (asynchronous) forces state = IDLE and load_buf = 0.
- While rst is high:
  - dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb and mem_stall are all 0.
  - mem_fault and mem_result follow the IDLE combinational rules.
- Reset mid-access (REQ or DONE): dmem_req drops in the same cycle rst rises. The access is abandoned; a write may or may not have committed in memory.
- Latency: an access with dmem_ready high on the first REQ cycle gives 2 stall cycles, with the result in cycle 3. Each extra cycle of dmem_ready low adds one stall cycle.
- dmem_ready outside REQ is ignored.
- Non-memory instructions and faults have 0 cycles of latency (pure pass-through).
- mem_stall is a combinational function of state and inputs. Upstream must hold all inputs stable while it is high.

## Test plan
- LD at addr 0x1000, dmem_rdata = 0x1122334455667788, ready on first REQ cycle:
  - Required: stall exactly 2 cycles, dmem_addr = 0x1000 in REQ.
  - Required: DONE mem_result = 0x1122334455667788.
- LB at 0x1003 with rdata 0x00000000_80000000 → mem_result = 0xFFFFFFFFFFFFFF80. LBU at the same address → mem_result = 0x80.
- SH at 0x1006, store_data = 0xABCD:
  - Required: dmem_we = 1, dmem_wstrb = 0xC0, dmem_wdata = 0xABCD000000000000, dmem_addr = 0x1000.
  - Required: dmem_ready held low 3 cycles gives a total stall of 5 cycles, with outputs stable throughout.
- LW at 0x1002 and SD at 0x1004 → mem_fault = 1, mem_stall = 0, dmem_req never asserts, mem_result = 0.
- ALU op with alu_fpu_result = 0xDEAD → mem_result = 0xDEAD, no stall, no request. Back-to-back LD, LD → two full IDLE-REQ-DONE sequences, no cycle lost between them.
- Assert rst during REQ with dmem_ready low → dmem_req and mem_stall drop in the same cycle. After release, the FSM is in IDLE, and a new LD completes normally.
